// File: rtl/ibpl_slot_ctrl.sv
// Slot sequencing controller: debounces the cardlet ID, brings the plugin up
// inputs-first then outputs, and latches plugin errors into a held fault.
module ibpl_slot_ctrl #(
  parameter int ID_W       = 8,
  parameter int CH         = 6,
  parameter int SETTLE_CYC = 1000,
  parameter int GAP_CYC    = 16
) (
  input  logic            clk_sys,
  input  logic            rstn_sys,
  input  logic [ID_W-1:0] slot_id_raw,
  input  logic [CH-1:0]   cfg_input_enable,
  input  logic [CH-1:0]   cfg_output_enable,
  input  logic            plugin_error,
  input  logic            err_clear,
  output logic [ID_W-1:0] active_id,
  output logic            id_valid,
  output logic [CH-1:0]   input_enable,
  output logic [CH-1:0]   output_enable,
  output logic            fault,
  output logic [ID_W-1:0] fault_id,
  output logic [2:0]      state
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_ARM    = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t state_q, next_state;

  logic [ID_W-1:0]  id_meta, id_s;
  logic [CNT_W-1:0] deb_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             id_ok, id_change, stable;

  logic [CH-1:0]    nxt_in, nxt_out;
  logic [ID_W-1:0]  nxt_active, nxt_fault_id;
  logic             nxt_fault;

  // id_meta is the value id_s takes next, so comparing them clears the
  // debounce counter on the same edge a new ID appears on id_s.
  assign id_ok     = (id_s != '0) && (id_s != '1);
  assign id_change = (id_meta != id_s);
  assign stable    = (deb_cnt == CNT_W'(SETTLE_CYC - 1));

  always_ff @(posedge clk_sys) begin
    if (!rstn_sys) begin
      id_meta <= '0;
      id_s    <= '0;
      deb_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      id_meta <= slot_id_raw;
      id_s    <= id_meta;
      if (id_change)
        deb_cnt <= '0;
      else if (!stable)
        deb_cnt <= deb_cnt + 1'b1;
      if (state_q == S_ARM)
        gap_cnt <= gap_cnt + 1'b1;
      else
        gap_cnt <= '0;
    end
  end

  always_comb begin
    next_state   = state_q;
    nxt_in       = '0;
    nxt_out      = '0;
    nxt_active   = active_id;
    nxt_fault    = fault;
    nxt_fault_id = fault_id;
    case (state_q)
      S_IDLE: begin
        if (id_ok)
          next_state = S_SETTLE;
      end
      S_SETTLE: begin
        if (!id_ok) begin
          next_state = S_IDLE;
        end else if (stable) begin
          next_state = S_ARM;
          nxt_active = id_s;
        end
      end
      S_ARM, S_RUN: begin
        // Fault entry outranks ID loss so fault_id captures the card that erred.
        if (plugin_error) begin
          next_state   = S_FAULT;
          nxt_fault    = 1'b1;
          nxt_fault_id = active_id;
        end else if (id_s != active_id) begin
          next_state = S_IDLE;
          nxt_active = '0;
        end else if (state_q == S_ARM) begin
          nxt_in = cfg_input_enable;
          if (gap_cnt == GAP_W'(GAP_CYC - 1))
            next_state = S_RUN;
        end else begin
          nxt_in  = cfg_input_enable;
          nxt_out = cfg_output_enable;
        end
      end
      S_FAULT: begin
        if (err_clear && !plugin_error) begin
          next_state = S_IDLE;
          nxt_fault  = 1'b0;
          nxt_active = '0;
        end
      end
      default: begin
        next_state = S_IDLE;
        nxt_active = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rstn_sys) begin
      state_q       <= S_IDLE;
      active_id     <= '0;
      id_valid      <= 1'b0;
      input_enable  <= '0;
      output_enable <= '0;
      fault         <= 1'b0;
      fault_id      <= '0;
    end else begin
      state_q       <= next_state;
      active_id     <= nxt_active;
      id_valid      <= (next_state == S_ARM) || (next_state == S_RUN);
      input_enable  <= nxt_in;
      output_enable <= nxt_out;
      fault         <= nxt_fault;
      fault_id      <= nxt_fault_id;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_ibpl_slot_ctrl.sv
// Directed bench for ibpl_slot_ctrl with SETTLE_CYC=8 and GAP_CYC=4; expected
// cycle positions are hand-derived from the synchronizer/debounce/gap timing.
module tb_ibpl_slot_ctrl;

  localparam int ID_W = 8;
  localparam int CH   = 6;

  logic            clk_sys = 1'b0;
  logic            rstn_sys;
  logic [ID_W-1:0] slot_id_raw;
  logic [CH-1:0]   cfg_input_enable;
  logic [CH-1:0]   cfg_output_enable;
  logic            plugin_error;
  logic            err_clear;
  logic [ID_W-1:0] active_id;
  logic            id_valid;
  logic [CH-1:0]   input_enable;
  logic [CH-1:0]   output_enable;
  logic            fault;
  logic [ID_W-1:0] fault_id;
  logic [2:0]      state;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_SETTLE = 3'd1, ST_ARM = 3'd2,
                         ST_RUN = 3'd3, ST_FAULT = 3'd4;

  ibpl_slot_ctrl #(.ID_W(ID_W), .CH(CH), .SETTLE_CYC(8), .GAP_CYC(4)) dut (
    .clk_sys           (clk_sys),
    .rstn_sys          (rstn_sys),
    .slot_id_raw       (slot_id_raw),
    .cfg_input_enable  (cfg_input_enable),
    .cfg_output_enable (cfg_output_enable),
    .plugin_error      (plugin_error),
    .err_clear         (err_clear),
    .active_id         (active_id),
    .id_valid          (id_valid),
    .input_enable      (input_enable),
    .output_enable     (output_enable),
    .fault             (fault),
    .fault_id          (fault_id),
    .state             (state)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic applyStimulus(input logic [ID_W-1:0] raw, input logic pe, input logic clr, input int n);
    slot_id_raw  = raw;
    plugin_error = pe;
    err_clear    = clr;
    step(n);
  endtask

  task automatic waitState(input logic [2:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (state !== target && n < budget) begin
      step(1);
      n++;
    end
    checkOutput(tag, {29'd0, state}, {29'd0, target});
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_in"}, {26'd0, input_enable}, 32'h0);
    checkOutput({tag, "_out"}, {26'd0, output_enable}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn_sys          = 1'b0;
    slot_id_raw       = 8'h21;
    cfg_input_enable  = 6'h3F;
    cfg_output_enable = 6'h0F;
    plugin_error      = 1'b0;
    err_clear         = 1'b0;
    step(3);
    checkOutput("rst_state", {29'd0, state}, {29'd0, ST_IDLE});
    checkQuiet("rst");
    checkOutput("rst_active", {24'd0, active_id}, 32'h0);
    checkOutput("rst_valid", {31'd0, id_valid}, 32'h0);
    checkOutput("rst_fault", {31'd0, fault}, 32'h0);
    checkOutput("rst_fault_id", {24'd0, fault_id}, 32'h0);

    // Bring-up: id_s valid at edge 2, SETTLE at 3, stable after 9, ARM at 10.
    rstn_sys = 1'b1;
    step(2);
    checkOutput("up_idle", {29'd0, state}, {29'd0, ST_IDLE});
    step(1);
    checkOutput("up_settle", {29'd0, state}, {29'd0, ST_SETTLE});
    step(6);
    checkOutput("up_settle_late", {29'd0, state}, {29'd0, ST_SETTLE});
    checkQuiet("up_settle");
    step(1);
    checkOutput("up_arm", {29'd0, state}, {29'd0, ST_ARM});
    checkOutput("up_arm_active", {24'd0, active_id}, 32'h21);
    checkOutput("up_arm_valid", {31'd0, id_valid}, 32'h1);
    checkOutput("up_arm_in0", {26'd0, input_enable}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      checkOutput("up_gap_in", {26'd0, input_enable}, 32'h3F);
      checkOutput("up_gap_out", {26'd0, output_enable}, 32'h0);
    end
    checkOutput("up_run", {29'd0, state}, {29'd0, ST_RUN});
    step(1);
    checkOutput("up_run_out", {26'd0, output_enable}, 32'h0F);
    checkOutput("up_run_active", {24'd0, active_id}, 32'h21);
    cfg_input_enable = 6'h15;
    step(1);
    checkOutput("cfg_follow", {26'd0, input_enable}, 32'h15);
    cfg_input_enable = 6'h3F;
    step(1);

    // Fault entry, blocked clear, real clear, re-bring-up.
    applyStimulus(8'h21, 1'b1, 1'b0, 1);
    checkOutput("flt_state", {29'd0, state}, {29'd0, ST_FAULT});
    checkQuiet("flt");
    checkOutput("flt_flag", {31'd0, fault}, 32'h1);
    checkOutput("flt_id", {24'd0, fault_id}, 32'h21);
    checkOutput("flt_valid", {31'd0, id_valid}, 32'h0);
    checkOutput("flt_active_held", {24'd0, active_id}, 32'h21);
    applyStimulus(8'h21, 1'b1, 1'b1, 1);
    checkOutput("flt_clr_blocked", {29'd0, state}, {29'd0, ST_FAULT});
    applyStimulus(8'h21, 1'b0, 1'b0, 2);
    checkOutput("flt_hold", {29'd0, state}, {29'd0, ST_FAULT});
    applyStimulus(8'h21, 1'b0, 1'b1, 1);
    checkOutput("clr_state", {29'd0, state}, {29'd0, ST_IDLE});
    checkOutput("clr_flag", {31'd0, fault}, 32'h0);
    checkOutput("clr_active", {24'd0, active_id}, 32'h0);
    checkOutput("clr_fault_id", {24'd0, fault_id}, 32'h21);
    err_clear = 1'b0;
    waitState(ST_RUN, 40, "resettle_run");
    checkOutput("resettle_active", {24'd0, active_id}, 32'h21);

    // Removal: shutdown on the 3rd edge after the pin change.
    applyStimulus(8'h00, 1'b0, 1'b0, 2);
    checkOutput("rm_still_run", {29'd0, state}, {29'd0, ST_RUN});
    checkOutput("rm_still_in", {26'd0, input_enable}, 32'h3F);
    step(1);
    checkOutput("rm_idle", {29'd0, state}, {29'd0, ST_IDLE});
    checkQuiet("rm");
    checkOutput("rm_active", {24'd0, active_id}, 32'h0);
    checkOutput("rm_valid", {31'd0, id_valid}, 32'h0);
    applyStimulus(8'h00, 1'b0, 1'b0, 20);
    checkOutput("rm_zero_idle", {29'd0, state}, {29'd0, ST_IDLE});
    applyStimulus(8'hFF, 1'b0, 1'b0, 20);
    checkOutput("rm_ones_idle", {29'd0, state}, {29'd0, ST_IDLE});
    checkQuiet("rm_ones");

    // Glitching ID never settles; holding 22 is accepted 10 edges after the pin change.
    for (int i = 0; i < 6; i++) begin
      slot_id_raw = (i % 2 == 0) ? 8'h22 : 8'h21;
      for (int j = 0; j < 5; j++) begin
        step(1);
        checkOutput("glitch_not_armed", {31'd0, state >= ST_ARM}, 32'h0);
        checkQuiet("glitch");
      end
    end
    slot_id_raw = 8'h22;
    step(9);
    checkOutput("glitch_hold_settle", {29'd0, state}, {29'd0, ST_SETTLE});
    step(1);
    checkOutput("glitch_hold_arm", {29'd0, state}, {29'd0, ST_ARM});
    checkOutput("glitch_hold_active", {24'd0, active_id}, 32'h22);
    waitState(ST_RUN, 20, "glitch_run");

    // ID loss and plugin_error seen on the same edge: fault wins.
    applyStimulus(8'h33, 1'b0, 1'b0, 2);
    checkOutput("sim_pre_run", {29'd0, state}, {29'd0, ST_RUN});
    plugin_error = 1'b1;
    step(1);
    checkOutput("sim_fault", {29'd0, state}, {29'd0, ST_FAULT});
    checkOutput("sim_fault_id", {24'd0, fault_id}, 32'h22);
    checkQuiet("sim");
    applyStimulus(8'h33, 1'b0, 1'b1, 1);
    checkOutput("sim_clr", {29'd0, state}, {29'd0, ST_IDLE});
    err_clear = 1'b0;
    waitState(ST_RUN, 40, "sim_rerun");
    checkOutput("sim_rerun_active", {24'd0, active_id}, 32'h33);

    // Mid-RUN reset for one edge, then a full re-debounce.
    rstn_sys = 1'b0;
    step(1);
    checkOutput("mrst_state", {29'd0, state}, {29'd0, ST_IDLE});
    checkQuiet("mrst");
    checkOutput("mrst_active", {24'd0, active_id}, 32'h0);
    checkOutput("mrst_valid", {31'd0, id_valid}, 32'h0);
    checkOutput("mrst_fault_id", {24'd0, fault_id}, 32'h0);
    rstn_sys = 1'b1;
    step(9);
    checkOutput("mrst_settle", {29'd0, state}, {29'd0, ST_SETTLE});
    step(1);
    checkOutput("mrst_arm", {29'd0, state}, {29'd0, ST_ARM});
    checkOutput("mrst_active_33", {24'd0, active_id}, 32'h33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibpl_slot_ctrl.md
# ibpl_slot_ctrl

Sequencing controller for one interbackplane cardlet slot on the SCU DIOB2. It debounces the slot's cardlet ID, brings the selected plugin up in two steps (inputs first, then outputs) and drives its `input_enable`/`output_enable` vectors. It also traps `plugin_error` into a latched fault that holds all drivers off until software clears it. The controller sits between the DIOB configuration registers and the cardlet plugin mux. An empty or unknown slot therefore never sees enables while the ID is unsettled.

## Interface
Parameters:
- `ID_W`, 8, cardlet ID width.
- `CH`, 6, channels per slot (width of enable vectors).
- `SETTLE_CYC`, 1000, consecutive stable cycles required to accept an ID (≥2).
- `GAP_CYC`, 16, cycles between input enable and output enable (≥1).

Ports:
- `clk_sys`, in, 1: system clock.
- `rstn_sys`, in, 1: reset. Synchronous, active-low, one clock domain.
- `slot_id_raw`, in, `ID_W`: asynchronous ID pins of the slot.
- `cfg_input_enable`, in, `CH`: requested input enables from the register file.
- `cfg_output_enable`, in, `CH`: requested output enables from the register file.
- `plugin_error`, in, 1: error flag from the currently selected plugin.
- `err_clear`, in, 1: single-cycle software clear strobe.
- `active_id`, out, `ID_W`: accepted ID and select for the plugin mux. It is 0 when no card is accepted.
- `id_valid`, out, 1: `active_id` is accepted and the state is ARM or RUN.
- `input_enable`, out, `CH`: registered input enables to the plugin.
- `output_enable`, out, `CH`: registered output enables to the plugin.
- `fault`, out, 1: latched fault indicator.
- `fault_id`, out, `ID_W`: the `active_id` value at the moment of fault entry.
- `state`, out, 3: IDLE=0, SETTLE=1, ARM=2, RUN=3, FAULT=4.

## Operation
- **Synchronizer.** `slot_id_raw` passes through a 2-FF synchronizer to give `id_s`.
- **Debounce counter.** The counter is `$clog2(SETTLE_CYC)` bits wide. It clears whenever `id_s` differs from its previous-cycle value; otherwise it increments and saturates at `SETTLE_CYC-1`. `stable` = counter == `SETTLE_CYC-1`.
- **Invalid IDs.** An ID of all-zeros or all-ones means "no card". It never leaves IDLE/SETTLE.
- **IDLE.** All enables are 0. If `id_s` is valid, go to SETTLE.
- **SETTLE.** All enables are 0.
  - If `id_s` becomes invalid, go to IDLE.
  - On `stable`, latch `active_id` ← `id_s`, clear the gap counter and go to ARM.
- **ARM.**
  - `input_enable` ← `cfg_input_enable`; `output_enable` ← 0.
  - The gap counter counts `GAP_CYC` cycles, then the state goes to RUN.
- **RUN.** `input_enable` ← `cfg_input_enable` and `output_enable` ← `cfg_output_enable`, re-registered every cycle. Configuration changes take effect one cycle later.
- **ID loss.** In ARM or RUN, if `id_s` ≠ `active_id`:
  - go to IDLE;
  - clear `active_id` to 0;
  - force all enables to 0.
- **Fault entry.** In ARM or RUN, `plugin_error`=1 for one cycle causes the following:
  - go to FAULT;
  - set `fault` ← 1 and `fault_id` ← `active_id`;
  - force all enables to 0.
- **FAULT.** All enables are 0 and `active_id` is held.
  - If `err_clear`=1 and `plugin_error`=0, go to IDLE. This clears `fault` and `active_id`; `fault_id` is held.
  - Otherwise stay in FAULT.
- **Priority.**
  - Reset has highest priority, then fault entry, then ID loss, then normal transitions.
  - `err_clear` outside FAULT is ignored.
  - `plugin_error` in IDLE or SETTLE is ignored, because no plugin is selected.

## Timing
- **Reset values.** While `rstn_sys`=0 at a clock edge, all outputs are 0 and `state`=IDLE. The synchronizer and the debounce and gap counters are also cleared. Reset asserted mid-RUN drops the enables at that edge.
- **ID acceptance latency.** A clean ID edge on `slot_id_raw` reaches `id_s` after 2 cycles. After that, it takes `SETTLE_CYC` more cycles until ARM, with `state` changing one cycle after `stable`.
- **Output enable latency.** `output_enable` becomes non-zero exactly `GAP_CYC` cycles after `input_enable` first follows the configuration.
- **Error response.** Enables are 0 in the cycle after `plugin_error` is sampled high: one edge of latency.
- **Removal response.** The ID-loss shutdown occurs 3 edges after the `slot_id_raw` change (2 synchronizer edges + 1).
- **No combinational paths.** There are no combinational paths from any input to any output.

## Test plan
- **Bring-up.** Release reset with `slot_id_raw`=8'h21, cfg in=6'h3F, cfg out=6'h0F, SETTLE_CYC=8, GAP_CYC=4 → IDLE→SETTLE→ARM.
  - `input_enable`=3F for 4 cycles with `output_enable`=0.
  - Then RUN with `output_enable`=0F and `active_id`=21.
- **Glitching ID.** Toggle `slot_id_raw` between 21 and 22 every 5 cycles → the state never leaves SETTLE and the enables stay 0. Hold at 22 → accepted after 8 stable cycles.
- **Fault.** Pulse `plugin_error` for 1 cycle in RUN → the next edge gives enables=0, `fault`=1, `fault_id`=21.
  - `err_clear` while `plugin_error`=1 → remains in FAULT.
  - `err_clear` with `plugin_error`=0 → IDLE, then the card re-settles.
- **Card removal.** In RUN, set `slot_id_raw`=8'h00 → enables=0 and `active_id`=0 at the 3rd edge; the state stays IDLE.
  - An all-ones ID also stays IDLE.
- **Simultaneous events.** In RUN, apply an ID change and `plugin_error` in the same cycle → FAULT is taken, not IDLE, and `fault_id`=old ID.
- **Mid-operation reset.** Assert `rstn_sys` low for 1 cycle in RUN → all outputs are 0 at that edge, followed by a full re-debounce.
